ifetch_queue: RTL

Instruction fetch queue feeding the dispatcher: it owns the program counter, issues reads to a synchronous instruction memory, and buffers fetched instructions with their PC+4 in a first-word-fall-through FIFO. It consumes the dispatcher's read enable and jump/branch redirect, and presents the head instruction, PC+4 and empty flag back to it. On a redirect it flushes all buffered and in-flight fetches and restarts from the target.

---
 rtl/ifetch_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue
// ------------------------------------------------------------------------
// Instruction fetch queue in front of the dispatcher. Owns the program
// counter, issues reads to a synchronous instruction memory (data returns
// one cycle after the read strobe), and buffers each returned instruction
// together with its PC+4 in a first-word-fall-through FIFO. A jump/branch
// redirect from the dispatcher flushes everything buffered or in flight and
// restarts fetching at the target address.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  program counter value after reset
//
// Ports
//   clk                       clock, rising edge
//   rst                       asynchronous active-high reset
//   imem_addr         [31:0]  fetch byte address (current PC)
//   imem_ren                  fetch issue strobe
//   imem_rdata        [31:0]  instruction word, valid the cycle after issue
//   dispatch_ren              pop the head entry (ignored when empty)
//   dispatch_jump_branch      redirect request
//   dispatch_jmp_branch_addr  [31:0] redirect target
//   ifetch_instruction [31:0] head instruction, 0 when empty
//   ifetch_pc_plus_four [31:0] head PC+4, 0 when empty
//   ifetch_empty_flag         no valid head
//
// Build option
//   IFQ_BYPASS_EN  when defined, a response arriving into an empty queue is
//                  presented at the head in the same cycle it returns from
//                  memory, and is not written if it is popped right away.
// ------------------------------------------------------------------------
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_ren,
    input  logic [31:0] imem_rdata,
    input  logic        dispatch_ren,
    input  logic        dispatch_jump_branch,
    input  logic [31:0] dispatch_jmp_branch_addr,
    output logic [31:0] ifetch_instruction,
    output logic [31:0] ifetch_pc_plus_four,
    output logic        ifetch_empty_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] count;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];

    logic          redirect;
    logic          fifo_empty;
    logic          bypass_valid;
    logic          pop;
    logic          wr_en;
    logic [PW:0]   occupancy;
    logic [31:0]   inflight_pc4;

    assign redirect     = dispatch_jump_branch;
    assign count        = wr_ptr - rd_ptr;
    assign fifo_empty   = (count == '0);
    assign inflight_pc4 = inflight_pc + 32'd4;

`ifdef IFQ_BYPASS_EN
    assign bypass_valid = fifo_empty && inflight;
`else
    assign bypass_valid = 1'b0;
`endif

    assign ifetch_empty_flag = fifo_empty && !bypass_valid;
    assign pop               = dispatch_ren && !ifetch_empty_flag;

    // A bypassed response that is popped in the same cycle never needs a slot.
    assign wr_en = inflight && !redirect && !(bypass_valid && pop);

    // Entries that will exist after this edge if no new fetch is issued.
    // Never negative: a pop needs either a stored entry or the bypassed
    // in-flight response.
    assign occupancy = (PW+1)'(count) + (PW+1)'(inflight) - (PW+1)'(pop);

    assign imem_ren  = !redirect && (occupancy < (PW+1)'(DEPTH));
    assign imem_addr = pc;

    always_comb begin
        ifetch_instruction  = 32'h0;
        ifetch_pc_plus_four = 32'h0;
        if (!fifo_empty) begin
            ifetch_instruction  = instr_mem[rd_ptr[AW-1:0]];
            ifetch_pc_plus_four = pc4_mem[rd_ptr[AW-1:0]];
        end else if (bypass_valid) begin
            ifetch_instruction  = imem_rdata;
            ifetch_pc_plus_four = inflight_pc4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight_pc <= 32'h0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect) begin
            // Flush: anything returning next cycle belongs to the old stream.
            pc       <= dispatch_jmp_branch_addr;
            inflight <= 1'b0;
            rd_ptr   <= wr_ptr;
        end else begin
            if (imem_ren) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
                inflight    <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !fifo_empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[wr_ptr[AW-1:0]] <= imem_rdata;
            pc4_mem[wr_ptr[AW-1:0]]   <= inflight_pc4;
        end
    end

endmodule
